// File: rtl/if_fetch_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_fetch_buf : fetch request issue, in-order response queue, decoder feed  |
// | Optional same-cycle response bypass when IF_BYPASS_EN is defined.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module if_fetch_buf #(
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter int PC_WIDTH        = 32,
   parameter int WORD_WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_en,
   input  logic [PC_WIDTH-1:0]   pc,
   input  logic                  flush,
   output logic                  pc_stall,
   output logic                  ibus_req,
   output logic [PC_WIDTH-1:0]   ibus_addr,
   input  logic                  ibus_gnt,
   input  logic                  ibus_rvalid,
   input  logic [WORD_WIDTH-1:0] ibus_rdata,
   output logic                  insn_valid,
   output logic [WORD_WIDTH-1:0] insn,
   output logic [PC_WIDTH-1:0]   insn_pc,
   input  logic                  id_ready
);

   localparam int c_IDX_W = $clog2(FIFO_DEPTH);
   localparam int c_PTR_W = c_IDX_W + 1;
   localparam int c_PQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int c_OUT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [PC_WIDTH-1:0]   r_mem_pc   [FIFO_DEPTH];
   logic [WORD_WIDTH-1:0] r_mem_word [FIFO_DEPTH];
   logic [c_PTR_W-1:0]    r_wptr;
   logic [c_PTR_W-1:0]    r_rptr;

   logic [PC_WIDTH-1:0]   r_pq [MAX_OUTSTANDING];
   logic [c_PQ_W-1:0]     r_pq_wr;
   logic [c_PQ_W-1:0]     r_pq_rd;

   logic [c_OUT_W-1:0]    r_outstanding;
   logic [c_OUT_W-1:0]    r_drop_cnt;

   logic [c_PTR_W-1:0]    w_fifo_count;
   logic                  w_fifo_empty;
   logic [c_OUT_W-1:0]    w_live;
   logic [31:0]           w_occupancy;
   logic                  w_credit;
   logic                  w_req;
   logic                  w_accept;
   logic                  w_dropping;
   logic                  w_drop_rsp;
   logic                  w_hit_rsp;
   logic                  w_keep_rsp;
   logic                  w_bypass;
   logic                  w_fifo_wr;
   logic                  w_fifo_rd;
   logic [c_OUT_W-1:0]    w_drop_dec;
   logic [c_OUT_W-1:0]    w_drop_add;
   logic [c_OUT_W-1:0]    w_drop_next;

   function automatic logic [c_PQ_W-1:0] pq_inc(input logic [c_PQ_W-1:0] p);
      if (p == c_PQ_W'(MAX_OUTSTANDING - 1)) begin
         return '0;
      end
      return p + c_PQ_W'(1);
   endfunction

   // Live requests are those still owed to the FIFO; dropped ones reserve nothing.
   assign w_fifo_count = r_wptr - r_rptr;
   assign w_fifo_empty = (r_wptr == r_rptr);
   assign w_live       = r_outstanding - r_drop_cnt;
   assign w_occupancy  = 32'(w_fifo_count) + 32'(w_live);
   assign w_credit     = (w_occupancy < 32'(FIFO_DEPTH)) &&
                         (32'(r_outstanding) < 32'(MAX_OUTSTANDING));

   assign w_req     = rst_n & cpu_en & w_credit & ~flush;
   assign w_accept  = w_req & ibus_gnt;
   assign ibus_req  = w_req;
   assign ibus_addr = pc;
   assign pc_stall  = ~w_accept & ~flush;

   assign w_dropping = (r_drop_cnt != '0);
   assign w_drop_rsp = ibus_rvalid & w_dropping;
   assign w_hit_rsp  = ibus_rvalid & ~w_dropping;
   assign w_keep_rsp = w_hit_rsp & ~flush;

`ifdef IF_BYPASS_EN
   assign w_bypass = rst_n & w_keep_rsp & w_fifo_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_fifo_wr = w_keep_rsp & ~(w_bypass & id_ready);
   assign w_fifo_rd = ~w_fifo_empty & id_ready & ~flush;

   always_comb begin
      insn_valid = 1'b0;
      insn       = '0;
      insn_pc    = '0;
      if (rst_n) begin
         if (!w_fifo_empty) begin
            insn_valid = 1'b1;
            insn       = r_mem_word[r_rptr[c_IDX_W-1:0]];
            insn_pc    = r_mem_pc[r_rptr[c_IDX_W-1:0]];
         end else if (w_bypass) begin
            insn_valid = 1'b1;
            insn       = ibus_rdata;
            insn_pc    = r_pq[r_pq_rd];
         end
      end
   end

   // On redirect every live request becomes a drop, minus one answered this cycle.
   assign w_drop_dec  = r_drop_cnt - c_OUT_W'(w_drop_rsp);
   assign w_drop_add  = w_live - c_OUT_W'(w_hit_rsp);
   assign w_drop_next = flush ? (w_drop_dec + w_drop_add) : w_drop_dec;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_fifo_wr) begin
            r_wptr <= r_wptr + c_PTR_W'(1);
         end
         if (w_fifo_rd) begin
            r_rptr <= r_rptr + c_PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && w_fifo_wr) begin
         r_mem_pc[r_wptr[c_IDX_W-1:0]]   <= r_pq[r_pq_rd];
         r_mem_word[r_wptr[c_IDX_W-1:0]] <= ibus_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pq_wr <= '0;
         r_pq_rd <= '0;
      end else begin
         if (w_accept) begin
            r_pq_wr <= pq_inc(r_pq_wr);
         end
         if (ibus_rvalid) begin
            r_pq_rd <= pq_inc(r_pq_rd);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && w_accept) begin
         r_pq[r_pq_wr] <= pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         case ({w_accept, ibus_rvalid})
            2'b10:   r_outstanding <= r_outstanding + c_OUT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - c_OUT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
         r_drop_cnt <= w_drop_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_if_fetch_buf : scoreboard bench with bus responder and PC generator     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_if_fetch_buf;
   localparam int FD = 4;
   localparam int MO = 2;
`ifdef IF_BYPASS_EN
   localparam logic c_BYP = 1'b1;
`else
   localparam logic c_BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, cpu_en, flush, ibus_gnt, ibus_rvalid, id_ready;
   logic [31:0] pc, ibus_rdata;
   logic        pc_stall, ibus_req, insn_valid;
   logic [31:0] ibus_addr, insn, insn_pc;

   if_fetch_buf #(.FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO), .PC_WIDTH(32), .WORD_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_en(cpu_en), .pc(pc), .flush(flush),
      .pc_stall(pc_stall), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
      .ibus_gnt(ibus_gnt), .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
      .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc), .id_ready(id_ready)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int          k_en, k_gnt, k_rv, k_ready, k_flush;
   logic [31:0] flush_tgt;
   logic [31:0] pc_next = 32'h0;
   int unsigned cyc = 0;
   int          n_accept = 0;
   logic [31:0] bus_q[$];
   int unsigned bus_c[$];
   logic [63:0] exp_q[$];
   logic [31:0] acc_log[$];

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000 ^ {a[15:0], a[31:16]};
   endfunction

   function automatic bit pct(input int k);
      return int'($urandom_range(99)) < k;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   // Inputs change just after the rising edge; return lands mid-high phase for checks.
   task automatic tick();
      @(posedge clk);
      #1;
      pc       = pc_next;
      cpu_en   = pct(k_en);
      ibus_gnt = pct(k_gnt);
      id_ready = pct(k_ready);
      flush    = pct(k_flush);
      if (bus_q.size() > 0 && bus_c[0] < cyc && pct(k_rv)) begin
         ibus_rvalid = 1'b1;
         ibus_rdata  = word_of(bus_q[0]);
      end else begin
         ibus_rvalid = 1'b0;
         ibus_rdata  = $urandom;
      end
      #2;
   endtask

   task automatic drain();
      k_en = 0; k_gnt = 0; k_rv = 100; k_ready = 100; k_flush = 0;
      repeat (8) tick();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: scoreboard, bus bookkeeping and PC generator model.
   always @(negedge clk) begin : mon
      logic [63:0] e;
      bit          acc;
      if (!rst_n) begin
         exp_q.delete();
         bus_q.delete();
         bus_c.delete();
         acc_log.delete();
         pc_next = 32'h0;
      end else begin
         acc = ibus_req && ibus_gnt;
         chk("pc_stall", 32'(pc_stall), 32'(!acc && !flush));
         if (!insn_valid) chk("insn_idle", insn, 32'h0);
         if (flush) chk("req_in_flush", 32'(ibus_req), 32'd0);
         if (ibus_req) chk("ibus_addr", ibus_addr, pc);
         if (insn_valid && id_ready && !flush) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_insn: got pc %h want none", insn_pc);
            end else begin
               e = exp_q.pop_front();
               chk("insn_pc", insn_pc, e[63:32]);
               chk("insn", insn, e[31:0]);
            end
         end
         if (ibus_rvalid && bus_q.size() > 0) begin
            void'(bus_q.pop_front());
            void'(bus_c.pop_front());
         end
         if (flush) exp_q.delete();
         if (acc) begin
            bus_q.push_back(pc);
            bus_c.push_back(cyc);
            exp_q.push_back({pc, word_of(pc)});
            acc_log.push_back(pc);
            n_accept++;
            chk("fifo_bound", 32'(exp_q.size() <= FD), 32'd1);
            chk("outstanding_bound", 32'(bus_q.size() <= MO), 32'd1);
         end
         pc_next = flush ? flush_tgt : (!pc_stall ? pc + 32'd4 : pc);
      end
      cyc++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          st;
      int          stalls;
      bit          found;
      logic [31:0] hold_pc;
      rst_n = 1'b0; cpu_en = 1'b0; flush = 1'b0; ibus_gnt = 1'b0;
      ibus_rvalid = 1'b0; ibus_rdata = '0; id_ready = 1'b0; pc = '0; flush_tgt = '0;
      k_en = 100; k_gnt = 100; k_rv = 100; k_ready = 100; k_flush = 0;

      repeat (4) begin
         tick();
         chk("rst_req", 32'(ibus_req), 32'd0);
         chk("rst_valid", 32'(insn_valid), 32'd0);
         chk("rst_insn", insn, 32'h0);
         chk("rst_insn_pc", insn_pc, 32'h0);
         chk("rst_stall", 32'(pc_stall), 32'd1);
      end
      rst_n = 1'b1;

      // Streaming with immediate grants and one-cycle responses.
      stalls = 0;
      repeat (20) begin
         tick();
         if (pc_stall) stalls++;
      end
      chk("stream_no_stall", 32'(stalls), 32'd0);
      chk("first_addr0", acc_log[0], 32'h0);
      chk("first_addr1", acc_log[1], 32'h4);
      chk("first_addr2", acc_log[2], 32'h8);
      drain();

      // Decoder blocked: the queue fills to exactly FIFO_DEPTH.
      k_en = 100; k_gnt = 100; k_rv = 100; k_ready = 0;
      st = n_accept;
      repeat (12) tick();
      chk("grants_when_blocked", 32'(n_accept - st), 32'(FD));
      chk("req_when_full", 32'(ibus_req), 32'd0);
      chk("stall_when_full", 32'(pc_stall), 32'd1);
      st = n_accept;
      k_ready = 100;
      tick();
      k_ready = 0;
      repeat (6) tick();
      chk("grant_after_pop", 32'(n_accept - st), 32'd1);
      drain();

      // Redirect with two requests in flight.
      flush_tgt = 32'h10; k_flush = 100; k_en = 100; tick();
      k_flush = 0; k_gnt = 100; k_rv = 0; k_ready = 100;
      repeat (2) tick();
      flush_tgt = 32'h100; k_flush = 100; tick();
      k_flush = 0; k_rv = 100;
      found = 1'b0;
      repeat (12) begin
         tick();
         if (!found && insn_valid && id_ready) begin
            found = 1'b1;
            chk("first_after_flush", insn_pc, 32'h100);
         end
      end
      if (!found) begin
         total++;
         bad++;
         $display("FAIL first_after_flush: got none want pc 00000100");
      end
      drain();

      // Redirect coinciding with a response.
      flush_tgt = 32'h20; k_flush = 100; k_en = 100; tick();
      k_flush = 0; k_gnt = 100; k_rv = 0; tick();
      k_gnt = 0; k_rv = 100; k_flush = 100; flush_tgt = 32'h200; tick();
      chk("valid_in_flush", 32'(insn_valid), 32'd0);
      chk("stall_in_flush", 32'(pc_stall), 32'd0);
      k_flush = 0; tick();
      chk("dropped_word", 32'(insn_valid), 32'd0);
      drain();

      // Grant withheld: address held and PC generator stalled.
      k_en = 100; k_gnt = 0; k_ready = 100;
      tick();
      hold_pc = pc;
      repeat (3) begin
         chk("hold_req", 32'(ibus_req), 32'd1);
         chk("hold_stall", 32'(pc_stall), 32'd1);
         chk("hold_addr", ibus_addr, hold_pc);
         tick();
      end
      k_gnt = 100; tick();
      chk("resume_accept", 32'(pc_stall), 32'd0);
      drain();

      // Response-to-valid latency.
      k_en = 100; k_gnt = 100; k_rv = 0; tick();
      k_en = 0; k_gnt = 0; k_rv = 100; k_ready = 100; tick();
      chk("valid_rsp_cycle", 32'(insn_valid), 32'(c_BYP));
      tick();
      chk("valid_next_cycle", 32'(insn_valid), 32'(!c_BYP));
      drain();

      // Randomized traffic with redirects.
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            k_en    = int'($urandom_range(60, 100));
            k_gnt   = int'($urandom_range(20, 100));
            k_rv    = int'($urandom_range(20, 100));
            k_ready = int'($urandom_range(10, 100));
            k_flush = int'($urandom_range(0, 8));
         end
         flush_tgt = 32'($urandom_range(0, 16383)) << 2;
         tick();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
